// File: rtl/seg7_display_scanner_if.sv
// Bundle between the CPU-side display register and the 7-segment scanner:
// the word to show, the live controls, and the board drive lines.
interface seg7_display_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [31:0]           value;
    logic                  enable;
    logic                  blankLeadingZeros;
    logic                  haltFlag;
    logic [6:0]            segments;
    logic                  dp;
    logic [NUM_DIGITS-1:0] anodes;

    modport master (
        output value, enable, blankLeadingZeros, haltFlag,
        input  segments, dp, anodes
    );

    modport slave (
        input  value, enable, blankLeadingZeros, haltFlag,
        output segments, dp, anodes
    );
endinterface

// File: rtl/seg7_display_scanner.sv
// Time-multiplexed hex display driver: one digit per slot with an anti-ghost blank
// at slot start, per-frame value snapshots, leading-zero blanking and a halt dp.
module seg7_display_scanner #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = 8,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_display_scanner_if.slave bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]         DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL     = {NUM_DIGITS{ACTIVE_LOW}};

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [DW-1:0]         digit_idx_q, digit_idx_d;
    logic [31:0]           snapshot_q, snapshot_d;
    logic                  first_q, first_d;
    state_t                state_q, state_d;
    logic [6:0]            segments_q, segments_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  next_in_blank;
    logic [3:0]            nibbles [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_tail;
    logic [3:0]            cur_nibble;
    logic                  lz_blank;
    logic                  drive;
    logic [NUM_DIGITS-1:0] onehot;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end    = (prescaler_q == PRESC_LAST);
    assign frame_end   = slot_end && (digit_idx_q == DIGIT_LAST);
    assign prescaler_d = slot_end ? '0 : prescaler_q + 1'b1;

    // The FSM state tracks the prescaler value it will sit beside next cycle.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign next_in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [PW-1:0] BLANK_P = PW'(BLANK_CYCLES);
            assign next_in_blank = (prescaler_d < BLANK_P);
        end
    endgenerate

    // lz_tail[i]: this digit and every more-significant digit of the snapshot are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibbles[gi] = snapshot_q[4*gi +: 4];
            assign lz_tail[gi] = (snapshot_q[NUM_DIGITS*4-1 : 4*gi] == '0);
        end
    endgenerate

    always_comb begin
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0 : digit_idx_q + 1'b1;
        end

        snapshot_d = (first_q || frame_end) ? bus.value : snapshot_q;
        first_d    = 1'b0;
        state_d    = next_in_blank ? ST_BLANK : ST_DRIVE;

        cur_nibble = nibbles[digit_idx_q];
        onehot     = NUM_DIGITS'(1) << digit_idx_q;
        lz_blank   = bus.blankLeadingZeros && lz_tail[digit_idx_q] && (digit_idx_q != '0);
        drive      = bus.enable && (state_q == ST_DRIVE) && !lz_blank;

        // Polarity is applied only here, so the rest of the logic is active-high.
        anodes_d   = (drive ? onehot : '0) ^ AN_POL;
        segments_d = (drive ? hex7(cur_nibble) : 7'h00) ^ SEG_POL;
        dp_d       = (drive && (digit_idx_q == '0) && bus.haltFlag) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            digit_idx_q <= '0;
            snapshot_q  <= '0;
            first_q     <= 1'b1;
            state_q     <= ST_BLANK;
            segments_q  <= SEG_POL;
            dp_q        <= ACTIVE_LOW;
            anodes_q    <= AN_POL;
        end else begin
            prescaler_q <= prescaler_d;
            digit_idx_q <= digit_idx_d;
            snapshot_q  <= snapshot_d;
            first_q     <= first_d;
            state_q     <= state_d;
            segments_q  <= segments_d;
            dp_q        <= dp_d;
            anodes_q    <= anodes_d;
        end
    end

    assign bus.segments = segments_q;
    assign bus.dp       = dp_q;
    assign bus.anodes   = anodes_q;

endmodule
